// File: rtl/port_deserializer_if.sv
// ---------------------------------------------------------------------------
// port_deserializer_if
// Bundles the serial input stream, the per-port output handshake and the
// status signals of port_deserializer.
// master: stream/consumer side. slave: the deserializer itself.
// ---------------------------------------------------------------------------
interface port_deserializer_if #(
   parameter int NPORT = 4,
   parameter int PW    = 2,
   parameter int W     = 8
);
   logic [PW-1:0]      port_num;
   logic               ser_in;
   logic               ser_valid;
   logic               done;
   logic [NPORT-1:0]   out_ready;
   logic               ovf_clr;
   logic [NPORT*W-1:0] out_data;
   logic [NPORT-1:0]   out_valid;
   logic [NPORT-1:0]   overflow;
   logic               busy;

   modport master (
      output port_num, ser_in, ser_valid, done, out_ready, ovf_clr,
      input  out_data, out_valid, overflow, busy
   );

   modport slave (
      input  port_num, ser_in, ser_valid, done, out_ready, ovf_clr,
      output out_data, out_valid, overflow, busy
   );
endinterface

// File: rtl/port_deserializer.sv
// ---------------------------------------------------------------------------
// port_deserializer
// Packs a routed serial stream MSB first into W-bit words and hands each word
// to the output port named at frame start. Every port has a one-entry holding
// register with valid/ready handshake and a sticky overflow flag.
// Optional feature macro: PORT_DESER_PARTIAL_FLUSH_EN
//   defined   -> a trailing partial word is left-aligned, zero-padded and
//                delivered through the FLUSH state
//   undefined -> a trailing partial word is discarded
// ---------------------------------------------------------------------------
module port_deserializer #(
   parameter int NPORT = 4,
   parameter int PW    = 2,
   parameter int W     = 8
) (
   input logic              clk,
   input logic              rst,
   port_deserializer_if.slave bus
);
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_FLUSH} state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [W-1:0]     r_sh;
   logic [W-1:0]     w_sh;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt;
   logic [PW-1:0]    r_cur_port;
   logic [PW-1:0]    w_cur_port;
   logic             w_frame_end;
   logic             w_load;
   logic [W-1:0]     w_word;
   logic             r_busy;
   logic [W-1:0]     r_data [NPORT];
   logic [NPORT-1:0] r_valid;
   logic [NPORT-1:0] r_ovf;

   // Next-state, shift/count datapath and word-load request.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      w_next_state = r_state;
      w_sh         = r_sh;
      w_cnt        = r_cnt;
      w_cur_port   = r_cur_port;
      w_frame_end  = 1'b0;
      w_load       = 1'b0;
      w_word       = '0;
      case (r_state)
         ST_IDLE: begin
            // done without a valid bit is ignored while idle
            if (bus.ser_valid) begin
               w_cur_port   = bus.port_num;
               w_sh         = {r_sh[W-2:0], bus.ser_in};
               w_cnt        = CW'(1);
               w_next_state = ST_COLLECT;
               w_frame_end  = bus.done;
            end
         end
         ST_COLLECT: begin
            if (bus.ser_valid) begin
               w_sh = {r_sh[W-2:0], bus.ser_in};
               if (r_cnt == CW'(W - 1)) begin
                  w_cnt  = '0;
                  w_load = 1'b1;
                  w_word = w_sh;
               end else begin
                  w_cnt = r_cnt + 1'b1;
               end
            end
            // done with or without a final bit closes the frame
            w_frame_end = bus.done;
         end
         ST_FLUSH: begin
            // upper bits of r_sh are stale; the shift pushes them out
            w_load       = 1'b1;
            w_word       = r_sh << (W - int'(r_cnt));
            w_cnt        = '0;
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase

      if (w_frame_end) begin
         if (w_cnt == '0) begin
            w_next_state = ST_IDLE;
         end else begin
`ifdef PORT_DESER_PARTIAL_FLUSH_EN
            w_next_state = ST_FLUSH;
`else
            w_next_state = ST_IDLE;
            w_cnt        = '0;
`endif
         end
      end
   end

   // FSM state, shift register, bit counter and registered busy flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_sh       <= '0;
         r_cnt      <= '0;
         r_cur_port <= '0;
         r_busy     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         r_state    <= w_next_state;
         r_sh       <= w_sh;
         r_cnt      <= w_cnt;
         r_cur_port <= w_cur_port;
         r_busy     <= (w_next_state != ST_IDLE);
      end
   end

   // Per-port holding registers: load, handshake drain and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the holding array is reset because out_data must read zero after reset.
         for (int p = 0; p < NPORT; p++) r_data[p] <= '0;
         r_valid <= '0;
         r_ovf   <= '0;
      end else begin
         for (int p = 0; p < NPORT; p++) begin
            if (bus.ovf_clr) r_ovf[p] <= 1'b0;
            if (w_load && (r_cur_port == PW'(p))) begin
               if (r_valid[p] && !bus.out_ready[p]) begin
                  // held word wins, new word dropped; set overrides a same-cycle clear
                  r_ovf[p] <= 1'b1;
               end else begin
                  r_data[p]  <= w_word;
                  r_valid[p] <= 1'b1;
               end
            end else if (r_valid[p] && bus.out_ready[p]) begin
               r_valid[p] <= 1'b0;
            end
         end
      end
   end

   genvar g;
   for (g = 0; g < NPORT; g++) begin : g_out
      assign bus.out_data[g*W +: W] = r_data[g];
   end

   assign bus.out_valid = r_valid;
   assign bus.overflow  = r_ovf;
   assign bus.busy      = r_busy;
endmodule
